wb_hyperram_mc: RTL

WB_HYPERRAM_MC -- requirements
Module: wb_hyperram_mc

---
 rtl/wb_hyperram_mc.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_hyperram_mc.sv
// Wishbone-to-HyperBus memory controller: one 32-bit access per Wishbone cycle, fixed 2x latency.
// Optional read watchdog enabled by defining HB_TIMEOUT_EN.
module wb_hyperram_mc #(
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned MEM_ADDR_W = 23,
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              hb_rstn_o,
  output logic [NUM_CS-1:0] hb_csn_o,
  output logic              hb_clk_o,
  output logic              hb_clkn_o,
  output logic              hb_rwds_o,
  output logic              hb_rwds_oen,
  input  logic              hb_rwds_i,
  output logic [7:0]        hb_dq_o,
  output logic              hb_dq_oen,
  input  logic [7:0]        hb_dq_i,
  output logic              err_o
);

  localparam int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned CNT_W   = $clog2(4 * LATENCY + 8);
  localparam int unsigned WA_W    = MEM_ADDR_W - 1;
  localparam int unsigned LAT_CYC = 4 * LATENCY;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CA, LAT, DATA_W, DATA_R, CS_HOLD, ACK
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [CS_W-1:0]     dev_q, dev_d;
  logic [47:0]         ca_q, ca_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         rd_buf_q, rd_buf_d;
  logic                abort_q, abort_d;
  logic                tmo_q, tmo_d;
  logic                rwds_prev_q;
  logic [NUM_CS-1:0]   csn_q, csn_d;
  logic                clk_q, clk_d;
  logic [7:0]          dq_q, dq_d;
  logic                dq_oen_q, dq_oen_d;
  logic                rwds_q, rwds_d;
  logic                rwds_oen_q, rwds_oen_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                rstn_q;
  logic                tmo_hit_c;
  logic [CS_W-1:0]     dev_sel_c;
  logic [WA_W-1:0]     word_addr_c;
  logic [47:0]         ca_word_c;
  logic                unused_adr_c;

  if (NUM_CS == 1) begin : g_single_cs
    assign dev_sel_c = '0;
  end else begin : g_multi_cs
    assign dev_sel_c = wbs_adr_i[MEM_ADDR_W +: CS_W];
  end

  assign word_addr_c  = wbs_adr_i[MEM_ADDR_W-1:1];
  assign ca_word_c    = {~wbs_we_i, 1'b0, 1'b1, 29'(word_addr_c >> 3), 13'd0, word_addr_c[2:0]};
  assign unused_adr_c = ^wbs_adr_i;

`ifdef HB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;

  // Watchdog counts DATA_R cycles; it restarts from zero each time DATA_R is entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == DATA_R) ? tmo_cnt_q + TMO_W'(1) : '0;
      if (tmo_hit_c) err_q <= 1'b1;
    end
  end

  assign tmo_hit_c = (state_q == DATA_R) && (tmo_cnt_q == TMO_W'(TIMEOUT));
  assign err_o     = err_q;
`else
  logic unused_tmo_c;
  assign unused_tmo_c = (TIMEOUT != 0);
  assign tmo_hit_c    = 1'b0;
  assign err_o        = 1'b0;
`endif

  // Next state, transaction context and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    dev_d    = dev_q;
    ca_d     = ca_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    rd_buf_d = rd_buf_q;
    abort_d  = abort_q;
    tmo_d    = tmo_q;
    dat_d    = dat_q;

    case (state_q)
      IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          state_d = CS_SETUP;
          we_d    = wbs_we_i;
          dev_d   = dev_sel_c;
          ca_d    = ca_word_c;
          wdat_d  = wbs_dat_i;
          sel_d   = wbs_sel_i;
          abort_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      CS_SETUP: begin
        state_d = CA;
        cnt_d   = '0;
      end
      CA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(5)) begin
          state_d = LAT;
          cnt_d   = '0;
        end
      end
      LAT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAT_CYC - 1)) begin
          state_d = we_q ? DATA_W : DATA_R;
          cnt_d   = '0;
        end
      end
      DATA_W: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(3)) state_d = CS_HOLD;
      end
      DATA_R: begin
        if (tmo_hit_c) begin
          state_d = CS_HOLD;
          tmo_d   = 1'b1;
        end else if (hb_rwds_i != rwds_prev_q) begin
          // Each RWDS edge carries one byte, stored in the same order writes are sent.
          case (cnt_q[1:0])
            2'd0:    rd_buf_d[15:8]  = hb_dq_i;
            2'd1:    rd_buf_d[7:0]   = hb_dq_i;
            2'd2:    rd_buf_d[31:24] = hb_dq_i;
            default: rd_buf_d[23:16] = hb_dq_i;
          endcase
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) state_d = CS_HOLD;
        end
      end
      CS_HOLD: begin
        state_d = ACK;
        if (!we_q) dat_d = tmo_q ? 32'hFFFF_FFFF : rd_buf_d;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !wbs_cyc_i) abort_d = 1'b1;

    csn_d      = '1;
    clk_d      = 1'b0;
    dq_d       = 8'h00;
    rwds_d     = 1'b0;
    dq_oen_d   = 1'b1;
    rwds_oen_d = 1'b1;
    ack_d      = (state_d == ACK) && !abort_d;

    if (state_d inside {CS_SETUP, CA, LAT, DATA_W, DATA_R})
      csn_d = ~(NUM_CS'(1) << dev_d);
    if (state_d inside {CA, LAT, DATA_W, DATA_R})
      clk_d = (state_q == CS_SETUP) ? 1'b1 : ~clk_q;

    if (state_d == CA) begin
      dq_oen_d = 1'b0;
      case (cnt_d[2:0])
        3'd0:    dq_d = ca_d[47:40];
        3'd1:    dq_d = ca_d[39:32];
        3'd2:    dq_d = ca_d[31:24];
        3'd3:    dq_d = ca_d[23:16];
        3'd4:    dq_d = ca_d[15:8];
        default: dq_d = ca_d[7:0];
      endcase
    end

    if (state_d == DATA_W) begin
      dq_oen_d   = 1'b0;
      rwds_oen_d = 1'b0;
      case (cnt_d[1:0])
        2'd0:    begin dq_d = wdat_d[15:8];  rwds_d = ~sel_d[1]; end
        2'd1:    begin dq_d = wdat_d[7:0];   rwds_d = ~sel_d[0]; end
        2'd2:    begin dq_d = wdat_d[31:24]; rwds_d = ~sel_d[3]; end
        default: begin dq_d = wdat_d[23:16]; rwds_d = ~sel_d[2]; end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      dev_q       <= '0;
      ca_q        <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      rd_buf_q    <= '0;
      abort_q     <= 1'b0;
      tmo_q       <= 1'b0;
      rwds_prev_q <= 1'b0;
      csn_q       <= '1;
      clk_q       <= 1'b0;
      dq_q        <= 8'h00;
      dq_oen_q    <= 1'b1;
      rwds_q      <= 1'b0;
      rwds_oen_q  <= 1'b1;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      dev_q       <= dev_d;
      ca_q        <= ca_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      rd_buf_q    <= rd_buf_d;
      abort_q     <= abort_d;
      tmo_q       <= tmo_d;
      rwds_prev_q <= hb_rwds_i;
      csn_q       <= csn_d;
      clk_q       <= clk_d;
      dq_q        <= dq_d;
      dq_oen_q    <= dq_oen_d;
      rwds_q      <= rwds_d;
      rwds_oen_q  <= rwds_oen_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    rstn_q <= ~wb_rst_i;
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign hb_rstn_o   = rstn_q;
  assign hb_csn_o    = csn_q;
  assign hb_clk_o    = clk_q;
  assign hb_clkn_o   = ~clk_q;
  assign hb_dq_o     = dq_q;
  assign hb_dq_oen   = dq_oen_q;
  assign hb_rwds_o   = rwds_q;
  assign hb_rwds_oen = rwds_oen_q;

endmodule
